// File: rtl/sram_ext_pkg.sv
// sram_ext_pkg: shared state encoding and default parameters for the SRAM extension controller
package sram_ext_pkg;
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_RD_CAP = 2'd3
    } state_t;
    localparam int          BW_DATA_DEF     = 64;
    localparam int          BW_ADDR_DEF     = 6;
    localparam logic [63:0] CLEAR_VALUE_DEF = 64'h0;
    localparam int          RSPQ_DEPTH_DEF  = 2;
endpackage

// File: rtl/sram_ext_rspq.sv
// sram_ext_rspq: 2-entry in-order response FIFO; head register reads 0 when empty
module sram_ext_rspq
    import sram_ext_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [BW_DATA-1:0] i_push_data,
    input  logic               i_pop,
    output logic [1:0]         o_count,
    output logic [BW_DATA-1:0] o_head
);
    logic [1:0]         r_count, w_count;
    logic [BW_DATA-1:0] r_q0, r_q1, w_q0, w_q1;
    logic               w_pop, w_push;

    // Pop shifts the second entry forward, then a push lands at the first free slot.
    always_comb begin
        w_pop   = i_pop && r_count != 2'd0;
        w_push  = i_push && (r_count != 2'd2 || w_pop);
        w_q0    = r_q0;
        w_q1    = r_q1;
        w_count = r_count;
        if (w_pop) begin
            w_q0    = r_q1;
            w_q1    = '0;
            w_count = r_count - 2'd1;
        end
        if (w_push) begin
            w_q0    = w_count == 2'd0 ? i_push_data : w_q0;
            w_q1    = w_count == 2'd0 ? w_q1 : i_push_data;
            w_count = w_count + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 2'd0;
            r_q0    <= '0;
            r_q1    <= '0;
        end else begin
            r_count <= w_count;
            r_q0    <= w_q0;
            r_q1    <= w_q1;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_q0;
endmodule

// File: rtl/sram_ext_ctrl.sv
// sram_ext_ctrl: sequences request-stream reads/writes into registered SRAM cycles and
// clears the whole array after every reset.
module sram_ext_ctrl
    import sram_ext_pkg::*;
#(
    parameter int                 BW_DATA     = BW_DATA_DEF,
    parameter int                 BW_ADDR     = BW_ADDR_DEF,
    parameter logic [BW_DATA-1:0] CLEAR_VALUE = BW_DATA'(CLEAR_VALUE_DEF),
    parameter int                 RSPQ_DEPTH  = RSPQ_DEPTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [BW_ADDR-1:0] i_req_addr,
    input  logic [BW_DATA-1:0] i_req_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_data,
    output logic               o_busy_init,
    output logic               o_mem_cen,
    output logic               o_mem_wen,
    output logic               o_mem_oen,
    output logic [BW_ADDR-1:0] o_mem_addr,
    output logic [BW_DATA-1:0] o_mem_data,
    input  logic [BW_DATA-1:0] i_mem_data
);
    state_t             r_state, w_state;
    logic [BW_ADDR-1:0] r_cnt, w_cnt, r_mem_addr, w_mem_addr;
    logic [BW_DATA-1:0] r_mem_data, w_mem_data;
    logic               r_mem_cen, r_mem_wen, r_mem_oen, w_mem_cen, w_mem_wen, w_mem_oen;
    logic               w_accept, w_push;
    logic [1:0]         w_count;

    assign o_busy_init = r_state == ST_INIT;
    assign o_req_ready = r_state == ST_IDLE && w_count < 2'(RSPQ_DEPTH);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_push      = r_state == ST_RD_CAP;

    // Mem pins are registered, so each branch computes the pins for the state being entered.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_mem_cen  = 1'b0;
        w_mem_wen  = 1'b0;
        w_mem_oen  = 1'b0;
        w_mem_addr = r_mem_addr;
        w_mem_data = r_mem_data;
        case (r_state)
            ST_INIT: begin
                w_mem_cen  = 1'b1;
                w_mem_wen  = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = CLEAR_VALUE;
                w_cnt      = r_cnt + BW_ADDR'(1);
                w_state    = &r_cnt ? ST_IDLE : ST_INIT;
            end
            ST_IDLE: if (w_accept) begin
                w_state    = ST_ISSUE;
                w_mem_cen  = 1'b1;
                w_mem_wen  = i_req_we;
                w_mem_addr = i_req_addr;
                w_mem_data = i_req_data;
            end
            ST_ISSUE: begin
                w_state   = r_mem_wen ? ST_IDLE : ST_RD_CAP;
                w_mem_oen = !r_mem_wen;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_mem_cen  <= 1'b0;
            r_mem_wen  <= 1'b0;
            r_mem_oen  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_mem_cen  <= w_mem_cen;
            r_mem_wen  <= w_mem_wen;
            r_mem_oen  <= w_mem_oen;
            r_mem_addr <= w_mem_addr;
            r_mem_data <= w_mem_data;
        end
    end

    assign o_mem_cen  = r_mem_cen;
    assign o_mem_wen  = r_mem_wen;
    assign o_mem_oen  = r_mem_oen;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;
    assign o_rsp_valid = w_count != 2'd0;

    sram_ext_rspq #(.BW_DATA(BW_DATA)) u_rspq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_push_data(i_mem_data),
        .i_pop      (i_rsp_ready),
        .o_count    (w_count),
        .o_head     (o_rsp_data)
    );
endmodule

// File: tb/tb_sram_ext_ctrl.sv
// tb_sram_ext_ctrl: directed bench for sram_ext_ctrl driving a behavioural 64x64 SRAM model
module tb_sram_ext_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [63:0] req_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        busy_init, mem_cen, mem_wen, mem_oen;
    logic [5:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    int n_vec = 0, n_err = 0;
    int n_wr = 0, bad_wr = 0, stale = 0;
    logic mon = 1'b0;

    logic [63:0] sram [64];
    logic [63:0] rd_q = '0;
    logic [5:0]  rd_a = '0;

    localparam logic [63:0] V0F = 64'h1111_0000_0000_000F;
    localparam logic [63:0] V10 = 64'h2222_0000_0000_0010;
    localparam logic [63:0] V1F = 64'h3333_0000_0000_001F;
    localparam logic [63:0] V20 = 64'h4444_0000_0000_0020;
    localparam logic [63:0] V3F = 64'h5555_0000_0000_003F;

    always #5 clk = ~clk;

    sram_ext_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_data (req_data),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_data (rsp_data),
        .o_busy_init(busy_init),
        .o_mem_cen  (mem_cen),
        .o_mem_wen  (mem_wen),
        .o_mem_oen  (mem_oen),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_wdata),
        .i_mem_data (mem_rdata)
    );

    // SRAM model: data only appears while oen is high and the launch address is still held.
    initial for (int i = 0; i < 64; i++) sram[i] = 64'hA5A5_A5A5_A5A5_A5A5 ^ 64'(i);
    always @(posedge clk) begin
        if (mem_cen && mem_wen) sram[mem_addr] <= mem_wdata;
        if (mem_cen && !mem_wen) begin
            rd_q <= sram[mem_addr];
            rd_a <= mem_addr;
        end
        if (mon && mem_cen && mem_wen) begin
            if (mem_addr != 6'(n_wr) || mem_wdata != 64'h0) bad_wr++;
            n_wr++;
        end
    end
    assign mem_rdata = (mem_oen && mem_addr == rd_a) ? rd_q : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [5:0] a, input logic [63:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        chk("req_accept_timeout", 64'(n < 200), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [63:0] exp);
        rsp_ready = 1'b0;
        req(1'b0, a, 64'h0);
        step();
        chk({tag, "_early"}, 64'(rsp_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_data"}, rsp_data, exp);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mon = 1'b1;
        step();
        step();
        chk("rst_busy", 64'(busy_init), 64'd1);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_mem_pins", {59'h0, mem_cen, mem_wen, mem_oen, 2'b00}, 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        rst       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'h3E;
        req_data  = 64'h77;
        for (int k = 1; k <= 64; k++) begin
            chk("init_busy", 64'(busy_init), 64'd1);
            chk("init_ready", 64'(req_ready), 64'd0);
            step();
        end
        chk("init_done_busy", 64'(busy_init), 64'd0);
        chk("init_done_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        mon = 1'b0;
        chk("init_write_count", 64'(n_wr), 64'd64);
        chk("init_write_order", 64'(bad_wr), 64'd0);

        req(1'b1, 6'h2A, 64'hDEAD_BEEF_0123_4567);
        rd_chk("rt_2a", 6'h2A, 64'hDEAD_BEEF_0123_4567);
        rd_chk("held_write_3e", 6'h3E, 64'h77);

        req(1'b1, 6'h0F, V0F);
        req(1'b1, 6'h10, V10);
        req(1'b1, 6'h1F, V1F);
        req(1'b1, 6'h20, V20);
        req(1'b1, 6'h3F, V3F);
        rd_chk("bank_0f", 6'h0F, V0F);
        rd_chk("bank_10", 6'h10, V10);
        rd_chk("bank_1f", 6'h1F, V1F);
        rd_chk("bank_20", 6'h20, V20);
        rd_chk("bank_3f", 6'h3F, V3F);
        rd_chk("unwritten_05", 6'h05, 64'h0);

        rsp_ready = 1'b0;
        req(1'b0, 6'h0F, 64'h0);
        req(1'b0, 6'h10, 64'h0);
        step();
        step();
        chk("bp_full_valid", 64'(rsp_valid), 64'd1);
        chk("bp_full_head", rsp_data, V0F);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'h1F;
        for (int k = 0; k < 4; k++) begin
            chk("bp_ready_low", 64'(req_ready), 64'd0);
            chk("bp_head_stable", rsp_data, V0F);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_pop1_head", rsp_data, V10);
        chk("bp_pop1_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        chk("bp_pop2_empty", 64'(rsp_valid), 64'd0);
        step();
        step();
        chk("bp_third_valid", 64'(rsp_valid), 64'd1);
        chk("bp_third_data", rsp_data, V1F);
        step();
        rsp_ready = 1'b0;
        chk("bp_drained", 64'(rsp_valid), 64'd0);

        req(1'b0, 6'h20, 64'h0);
        step();
        step();
        chk("pp_first_head", rsp_data, V20);
        req(1'b0, 6'h3F, 64'h0);
        step();
        chk("pp_before_head", rsp_data, V20);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("pp_valid", 64'(rsp_valid), 64'd1);
        chk("pp_new_head", rsp_data, V3F);
        step();
        chk("pp_head_stable", rsp_data, V3F);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("pp_count_one", 64'(rsp_valid), 64'd0);

        req(1'b0, 6'h0F, 64'h0);
        step();
        step();
        chk("mr_queued", 64'(rsp_valid), 64'd1);
        req(1'b0, 6'h10, 64'h0);
        step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        n_wr   = 0;
        bad_wr = 0;
        mon    = 1'b1;
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_rsp_data", rsp_data, 64'h0);
        chk("mr_busy", 64'(busy_init), 64'd1);
        chk("mr_ready", 64'(req_ready), 64'd0);
        chk("mr_mem_cen", 64'(mem_cen), 64'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 66; k++) begin
            if (rsp_valid) stale++;
            step();
        end
        rsp_ready = 1'b0;
        mon = 1'b0;
        chk("mr_stale_rsp", 64'(stale), 64'd0);
        chk("mr_sweep_count", 64'(n_wr), 64'd64);
        chk("mr_sweep_order", 64'(bad_wr), 64'd0);
        rd_chk("mr_cleared_0f", 6'h0F, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_ext_ctrl.md
Name: sram_ext_ctrl

Overview:
- Request-side controller that sits directly upstream of the 64x64 banked SRAM extension (the 8-instance spsram array) and drives its i_data/i_addr/i_wen/i_cen/i_oen pins.
- Converts a valid/ready request stream (read or write) into correctly sequenced SRAM cycles.
- Captures read data into a 2-entry response queue with valid/ready backpressure.
- Clears the whole array to CLEAR_VALUE after every reset.

Parameters:
- BW_DATA, 64, data width of request, response and memory data.
- BW_ADDR, 6, word address width; the array depth is 2**BW_ADDR.
- CLEAR_VALUE, 64'h0, word written to every address during the init sweep.
- RSPQ_DEPTH, 2, response queue depth; fixed at 2, not otherwise supported.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when i_req_valid && o_req_ready.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  BW_ADDR  word address.
- i_req_data  in  BW_DATA  write data; ignored for reads.
- o_rsp_valid  out  1  read data valid.
- i_rsp_ready  in  1  response consumed when o_rsp_valid && i_rsp_ready.
- o_rsp_data  out  BW_DATA  read data, returned in request order.
- o_busy_init  out  1  high while the clear sweep runs.
- o_mem_cen  out  1  SRAM chip enable (active-high), to i_cen.
- o_mem_wen  out  1  SRAM write enable (active-high), to i_wen.
- o_mem_oen  out  1  SRAM output enable (active-high), to i_oen.
- o_mem_addr  out  BW_ADDR  SRAM address, to i_addr.
- o_mem_data  out  BW_DATA  SRAM write data, to i_data.
- i_mem_data  in  BW_DATA  SRAM read data, from o_data.

Behaviour:
- SRAM timing contract:
  - Write occurs at the clock edge that ends a cycle with cen=1, wen=1.
  - Read is launched at the edge ending a cycle with cen=1, wen=0.
  - Read data is valid on i_mem_data during the following cycle while oen=1 and addr is held unchanged. Address is held because oen bank-select decodes addr[5:4].
- All o_mem_* outputs are registered. o_req_ready is a combinational function of state and queue count.
- Reset (i_rst=1 at an edge):
  - state=INIT, sweep counter=0, queue flushed (count=0, pointers=0).
  - All o_mem_* = 0, o_rsp_valid=0, o_rsp_data=0, o_busy_init=1, o_req_ready=0.
- FSM states INIT, IDLE, ISSUE, RD_CAP:
  - INIT:
    - Each cycle drive cen=1, wen=1, oen=0, addr=counter, data=CLEAR_VALUE; counter increments.
    - After address 2**BW_ADDR-1 is written, go to IDLE and drop o_busy_init.
    - The sweep takes exactly 2**BW_ADDR cycles (64 by default).
  - IDLE:
    - o_req_ready = (count < RSPQ_DEPTH). Mem outputs idle (cen=wen=oen=0; addr/data hold last value).
    - On accept: register addr/data/we into mem outputs and go to ISSUE.
  - ISSUE:
    - cen=1, wen=we, oen=0.
    - Write: go to IDLE.
    - Read: go to RD_CAP.
  - RD_CAP:
    - cen=0, wen=0, oen=1, addr held.
    - At the ending edge, push i_mem_data into the queue; go to IDLE.
  - o_req_ready=0 in INIT, ISSUE and RD_CAP.
- Latency and throughput:
  - Write accepted at cycle T: memory written at end of T+1; one write per 2 cycles.
  - Read accepted at T: o_rsp_valid=1 at T+3 if the queue was empty; one read per 3 cycles.
- Response queue:
  - FIFO, in-order.
  - o_rsp_valid = (count != 0). o_rsp_data = head entry, registered, 0 when empty.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Overflow is impossible: a read is only accepted when count<2, and count never rises between accept and push.
  - With i_rsp_ready=0, o_rsp_valid/o_rsp_data stay stable.
- Reset mid-operation (any state):
  - In-flight read is dropped and queued responses are discarded.
  - Sweep restarts from address 0.
- Addresses wrap naturally in BW_ADDR bits. No address checking.

Decomposition:
- Shared package sram_ext_pkg: FSM state encoding (ST_INIT, ST_IDLE, ST_ISSUE, ST_RD_CAP, 2-bit), default BW_DATA/BW_ADDR, CLEAR_VALUE.
- One sub-module, sram_ext_rspq: 2-entry FIFO with push/pop, count and head data, synchronous active-high reset.
- The FSM and mem-output registers live in sram_ext_ctrl.
- The bench instantiates sram_ext_ctrl feeding the existing SRAM extension.

Test Plan:
- Init sweep:
  - Stimulus: release i_rst, hold i_req_valid=1.
  - Response: o_busy_init=1 and o_req_ready=0 for exactly 64 cycles; addr 0x00..0x3F each written with CLEAR_VALUE; ready=1 on cycle 65.
- Write/read round trip:
  - Stimulus: write 64'hDEAD_BEEF_0123_4567 to 0x2A, then read 0x2A.
  - Response: o_rsp_valid 3 cycles after read accept, o_rsp_data=64'hDEAD_BEEF_0123_4567.
- Bank boundaries:
  - Stimulus: write distinct values to 0x0F, 0x10, 0x1F, 0x20, 0x3F, then read all five in order.
  - Response: all five values returned unchanged, in order, with no cross-bank aliasing; an unwritten address (0x05) reads 0.
- Backpressure:
  - Stimulus: i_rsp_ready=0; issue 3 reads.
  - Response: 2 accepted; o_req_ready=0 afterwards; o_rsp_data stable.
  - Stimulus: raise i_rsp_ready.
  - Response: both responses pop in order, then the third read is accepted.
- Simultaneous push/pop:
  - Stimulus: count=1, i_rsp_ready=1 during the RD_CAP edge.
  - Response: count stays 1 and the new data becomes head.
- Reset mid-read:
  - Stimulus: assert i_rst in RD_CAP with 1 queued response.
  - Response: o_rsp_valid=0 next cycle, o_busy_init=1, sweep restarts at addr 0, no stale response ever appears.
